// File: rtl/display_pkg.sv
// Shared glyph constants and segment bit order for the 7-segment scan driver.
package display_pkg;

  // Segment bit positions inside a 7-bit glyph: a is the MSB, g the LSB.
  localparam int SEG_W = 7;
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  typedef logic [SEG_W-1:0] glyph_t;

  // Active-high glyphs, ordered a..g.
  localparam glyph_t GLYPH_0    = 7'b1111110;
  localparam glyph_t GLYPH_1    = 7'b0110000;
  localparam glyph_t GLYPH_2    = 7'b1101101;
  localparam glyph_t GLYPH_3    = 7'b1111001;
  localparam glyph_t GLYPH_4    = 7'b0110011;
  localparam glyph_t GLYPH_5    = 7'b1011011;
  localparam glyph_t GLYPH_6    = 7'b1011111;
  localparam glyph_t GLYPH_7    = 7'b1110000;
  localparam glyph_t GLYPH_8    = 7'b1111111;
  localparam glyph_t GLYPH_9    = 7'b1111011;
  localparam glyph_t GLYPH_A    = 7'b1110111;
  localparam glyph_t GLYPH_B    = 7'b0011111;
  localparam glyph_t GLYPH_C    = 7'b1001110;
  localparam glyph_t GLYPH_D    = 7'b0111101;
  localparam glyph_t GLYPH_E    = 7'b1001111;
  localparam glyph_t GLYPH_F    = 7'b1000111;
  localparam glyph_t GLYPH_DASH = 7'b0000001;
  localparam glyph_t GLYPH_OFF  = 7'b0000000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to active-high a..g glyph; codes 10-15 are
// either hex letters or a dash depending on hex_mode_i.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       hex_mode_i,
  output glyph_t     glyph_o
);

  // Glyph lookup.
  always_comb begin
    glyph_o = GLYPH_OFF;
    case (code_i)
      4'h0: glyph_o = GLYPH_0;
      4'h1: glyph_o = GLYPH_1;
      4'h2: glyph_o = GLYPH_2;
      4'h3: glyph_o = GLYPH_3;
      4'h4: glyph_o = GLYPH_4;
      4'h5: glyph_o = GLYPH_5;
      4'h6: glyph_o = GLYPH_6;
      4'h7: glyph_o = GLYPH_7;
      4'h8: glyph_o = GLYPH_8;
      4'h9: glyph_o = GLYPH_9;
      4'hA: glyph_o = hex_mode_i ? GLYPH_A : GLYPH_DASH;
      4'hB: glyph_o = hex_mode_i ? GLYPH_B : GLYPH_DASH;
      4'hC: glyph_o = hex_mode_i ? GLYPH_C : GLYPH_DASH;
      4'hD: glyph_o = hex_mode_i ? GLYPH_D : GLYPH_DASH;
      4'hE: glyph_o = hex_mode_i ? GLYPH_E : GLYPH_DASH;
      4'hF: glyph_o = hex_mode_i ? GLYPH_F : GLYPH_DASH;
      default: glyph_o = GLYPH_OFF;
    endcase
  end

endmodule

// File: rtl/display_7seg_mux.sv
// Time-multiplexed DIGITS-wide 7-segment driver: latches a packed BCD/hex
// word, scans one digit per PRESCALE cycles, blanks leading zeros on demand
// and drives registered, polarity-adjusted pins.
module display_7seg_mux
  import display_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 50000,
  parameter int HEX_MODE       = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   iBCD,
  input  logic [DIGITS-1:0]     iDP,
  input  logic                  lz_en,
  output logic [6:0]            abcdefg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     anode,
  output logic                  frame_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);
  localparam logic HEX     = (HEX_MODE != 0);

  logic [PW-1:0]             pcnt_q, pcnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      wrap_q, wrap_d;
  logic [4*DIGITS-1:0]       data_q;
  logic [DIGITS-1:0]         dp_q;
  logic [6:0]                seg_q;
  logic                      dpo_q;
  logic [DIGITS-1:0]         an_q;
  logic                      tick_q;

  logic [DIGITS-1:0][3:0]    digit_w;
  logic [3:0]                code_w;
  logic                      dp_w;
  logic [DIGITS-1:0]         onehot_w;
  logic                      blank_w;
  logic                      zero_run;
  glyph_t                    glyph_w;

  assign digit_w = data_q;

  // Prescaler and digit index advance; wrap_d marks the last cycle of a frame.
  always_comb begin
    pcnt_d = pcnt_q + 1'b1;
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (pcnt_q == PCNT_LAST) begin
      pcnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d  = '0;
        wrap_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Select the scanned digit and decide leading-zero blanking; zero_run
  // tracks whether every digit from the top down to j is zero.
  always_comb begin
    code_w   = '0;
    dp_w     = 1'b0;
    onehot_w = '0;
    blank_w  = 1'b0;
    zero_run = 1'b1;
    for (int j = DIGITS - 1; j >= 0; j--) begin
      zero_run = zero_run && (digit_w[j] == 4'd0);
      if (IW'(j) == idx_q) begin
        code_w      = digit_w[j];
        dp_w        = dp_q[j];
        onehot_w[j] = 1'b1;
        if (j > 0) blank_w = zero_run;
      end
    end
    blank_w = blank_w && lz_en;
  end

  seg7_decode u_dec (
    .code_i     (code_w),
    .hex_mode_i (HEX),
    .glyph_o    (glyph_w)
  );

  // Scan counters and the captured display word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
      data_q <= '0;
      dp_q   <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      if (load) begin
        data_q <= iBCD;
        dp_q   <= iDP;
      end
    end
  end

  // Pin register: decoded digit with polarity applied; the tick is delayed
  // one cycle so it lines up with digit 0 appearing on the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q  <= {7{SEG_INV}};
      dpo_q  <= SEG_INV;
      an_q   <= {DIGITS{AN_INV}};
      tick_q <= 1'b0;
    end else begin
      seg_q  <= (blank_w ? GLYPH_OFF : glyph_w) ^ {7{SEG_INV}};
      dpo_q  <= (dp_w && !blank_w) ^ SEG_INV;
      an_q   <= (blank_w ? '0 : onehot_w) ^ {DIGITS{AN_INV}};
      tick_q <= wrap_q;
    end
  end

  assign abcdefg    = seg_q;
  assign dp_out     = dpo_q;
  assign anode      = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_7seg_mux.sv
// Bench for display_7seg_mux: five instances with different parameters share
// one stimulus stream and are checked every cycle against a cycle-count model.
module tb_display_7seg_mux;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       tick;
  } exp_t;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dpv;
    logic        lz;
    int          dig;
    logic [6:0]  seg;
    logic [6:0]  seg_h0;
    logic        dpo;
    logic [3:0]  an;
  } vec_t;

  localparam int NI = 5;
  int PD [NI] = '{4, 4, 4, 1, 3};
  int PP [NI] = '{4, 4, 4, 1, 2};
  int PH [NI] = '{1, 0, 1, 1, 1};
  int PSL[NI] = '{0, 0, 1, 0, 0};
  int PAL[NI] = '{0, 0, 1, 0, 1};

  logic        clk = 1'b0;
  logic        rst, load, lz;
  logic [15:0] bcd;
  logic [3:0]  dpi;

  logic [6:0]  seg [NI];
  logic        dpo [NI];
  logic        tk  [NI];
  logic [3:0]  an  [NI];
  logic [3:0]  an0, an1, an2;
  logic [0:0]  an3;
  logic [2:0]  an4;

  assign an[0] = an0;
  assign an[1] = an1;
  assign an[2] = an2;
  assign an[3] = {3'b000, an3};
  assign an[4] = {1'b0, an4};

  always #5 clk = ~clk;

  display_7seg_mux #(.DIGITS(4), .PRESCALE(4), .HEX_MODE(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) u0 (
    .clk(clk), .rst(rst), .load(load), .iBCD(bcd), .iDP(dpi), .lz_en(lz),
    .abcdefg(seg[0]), .dp_out(dpo[0]), .anode(an0), .frame_tick(tk[0]));
  display_7seg_mux #(.DIGITS(4), .PRESCALE(4), .HEX_MODE(0), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) u1 (
    .clk(clk), .rst(rst), .load(load), .iBCD(bcd), .iDP(dpi), .lz_en(lz),
    .abcdefg(seg[1]), .dp_out(dpo[1]), .anode(an1), .frame_tick(tk[1]));
  display_7seg_mux #(.DIGITS(4), .PRESCALE(4), .HEX_MODE(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u2 (
    .clk(clk), .rst(rst), .load(load), .iBCD(bcd), .iDP(dpi), .lz_en(lz),
    .abcdefg(seg[2]), .dp_out(dpo[2]), .anode(an2), .frame_tick(tk[2]));
  display_7seg_mux #(.DIGITS(1), .PRESCALE(1), .HEX_MODE(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) u3 (
    .clk(clk), .rst(rst), .load(load), .iBCD(bcd[3:0]), .iDP(dpi[0:0]), .lz_en(lz),
    .abcdefg(seg[3]), .dp_out(dpo[3]), .anode(an3), .frame_tick(tk[3]));
  display_7seg_mux #(.DIGITS(3), .PRESCALE(2), .HEX_MODE(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) u4 (
    .clk(clk), .rst(rst), .load(load), .iBCD(bcd[11:0]), .iDP(dpi[2:0]), .lz_en(lz),
    .abcdefg(seg[4]), .dp_out(dpo[4]), .anode(an4), .frame_tick(tk[4]));

  // Model state: edges since reset release and the word last captured.
  int          n;
  logic [15:0] mdata;
  logic [3:0]  mdp;
  exp_t        ex [NI];
  int          asserts = 0;
  int          fails   = 0;

  function automatic logic [6:0] glyph(logic [3:0] c, int hex);
    case (c)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      default: begin
        if (hex == 0) return 7'b0000001;
        case (c)
          4'hA: return 7'b1110111;
          4'hB: return 7'b0011111;
          4'hC: return 7'b1001110;
          4'hD: return 7'b0111101;
          4'hE: return 7'b1001111;
          default: return 7'b1000111;
        endcase
      end
    endcase
  endfunction

  // Output after edge n: digit ((n-1)/P) mod D of the word held before that edge.
  function automatic exp_t model(int D, int P, int hex, int sal, int aal, int cnt,
                                 logic [15:0] data, logic [3:0] dpv, logic lzv);
    exp_t        e;
    int          idx;
    logic [15:0] dm;
    logic [15:0] upper;
    logic [3:0]  anmask;
    anmask = 4'((1 << D) - 1);
    e      = '0;
    if (cnt > 0) begin
      idx    = ((cnt - 1) / P) % D;
      dm     = data & 16'((32'd1 << (4 * D)) - 1);
      upper  = dm >> (4 * idx);
      e.tick = (cnt > 1) && (((cnt - 1) % (D * P)) == 0);
      if (!(lzv && idx != 0 && upper == 16'd0)) begin
        e.seg = glyph(upper[3:0], hex);
        e.dp  = dpv[idx];
        e.an  = 4'(1 << idx);
      end
    end
    if (sal != 0) begin
      e.seg = ~e.seg;
      e.dp  = ~e.dp;
    end
    if (aal != 0) e.an = ~e.an & anmask;
    return e;
  endfunction

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] expv);
    asserts++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s u%0d t=%0t got %b expected %b", nm, i, $time, act, expv);
    end
  endtask

  task automatic compute_exp();
    for (int i = 0; i < NI; i++)
      ex[i] = model(PD[i], PP[i], PH[i], PSL[i], PAL[i], n, mdata, mdp, lz);
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      chk("seg",  i, 32'(seg[i]), 32'(ex[i].seg));
      chk("dp",   i, 32'(dpo[i]), 32'(ex[i].dp));
      chk("an",   i, 32'(an[i]),  32'(ex[i].an));
      chk("tick", i, 32'(tk[i]),  32'(ex[i].tick));
    end
  endtask

  // One clock edge; inputs are whatever the caller set before.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      n = 0; mdata = '0; mdp = '0;
      compute_exp();
    end else begin
      n++;
      compute_exp();
      if (load) begin
        mdata = bcd;
        mdp   = dpi;
      end
    end
    #1;
    compare_all();
  endtask

  // Short reset pulse between edges; outputs must go idle without a clock.
  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    n = 0; mdata = '0; mdp = '0;
    compute_exp();
    compare_all();
    #1 rst = 1'b0;
  endtask

  function automatic int cur_idx();
    return (n > 0) ? ((n - 1) / 4) % 4 : -1;
  endfunction

  // Step until u0 shows digit dig at phase ph (ph<0: any phase), bounded.
  task automatic step_until(int dig, int ph);
    int  k;
    bit  hit;
    k   = 0;
    hit = 0;
    while (!hit && k < 64) begin
      step();
      k++;
      hit = (cur_idx() == dig) && (ph < 0 || ((n - 1) % 4) == ph);
    end
    if (!hit) begin
      asserts++;
      fails++;
      $display("FAIL step_until timeout dig=%0d ph=%0d", dig, ph);
    end
  endtask

  vec_t tbl [12];
  int   tc;

  initial begin
    tbl[0]  = '{16'h1234, 4'b0000, 1'b0, 0, 7'b0110011, 7'b0110011, 1'b0, 4'b0001};
    tbl[1]  = '{16'h1234, 4'b0000, 1'b0, 1, 7'b1111001, 7'b1111001, 1'b0, 4'b0010};
    tbl[2]  = '{16'h1234, 4'b0000, 1'b0, 2, 7'b1101101, 7'b1101101, 1'b0, 4'b0100};
    tbl[3]  = '{16'h1234, 4'b0000, 1'b0, 3, 7'b0110000, 7'b0110000, 1'b0, 4'b1000};
    tbl[4]  = '{16'h0050, 4'b0000, 1'b1, 3, 7'b0000000, 7'b0000000, 1'b0, 4'b0000};
    tbl[5]  = '{16'h0050, 4'b0000, 1'b1, 2, 7'b0000000, 7'b0000000, 1'b0, 4'b0000};
    tbl[6]  = '{16'h0050, 4'b0000, 1'b1, 1, 7'b1011011, 7'b1011011, 1'b0, 4'b0010};
    tbl[7]  = '{16'h0050, 4'b0000, 1'b1, 0, 7'b1111110, 7'b1111110, 1'b0, 4'b0001};
    tbl[8]  = '{16'h0000, 4'b0000, 1'b1, 0, 7'b1111110, 7'b1111110, 1'b0, 4'b0001};
    tbl[9]  = '{16'h0000, 4'b0010, 1'b1, 1, 7'b0000000, 7'b0000000, 1'b0, 4'b0000};
    tbl[10] = '{16'h000A, 4'b0001, 1'b0, 0, 7'b1110111, 7'b0000001, 1'b1, 4'b0001};
    tbl[11] = '{16'h000A, 4'b0001, 1'b0, 1, 7'b1111110, 7'b1111110, 1'b0, 4'b0010};

    rst = 1'b1; load = 1'b0; lz = 1'b0; bcd = '0; dpi = '0;
    n = 0; mdata = '0; mdp = '0;

    // Reset before any clock edge, then held across one edge.
    #2;
    compute_exp();
    compare_all();
    chk("rst_an_lo", 2, 32'(an[2]), 32'hF);
    chk("rst_seg_lo", 2, 32'(seg[2]), 32'h7F);
    step();
    rst = 1'b0;
    step();
    chk("first_seg", 0, 32'(seg[0]), 32'b1111110);
    chk("first_an",  0, 32'(an[0]),  32'b0001);

    // Table-driven directed vectors.
    foreach (tbl[v]) begin
      load = 1'b1; bcd = tbl[v].bcd; dpi = tbl[v].dpv; lz = tbl[v].lz;
      step();
      load = 1'b0;
      step_until(tbl[v].dig, -1);
      chk($sformatf("tbl%0d_seg", v), 0, 32'(seg[0]), 32'(tbl[v].seg));
      chk($sformatf("tbl%0d_hex0", v), 1, 32'(seg[1]), 32'(tbl[v].seg_h0));
      chk($sformatf("tbl%0d_dp", v), 0, 32'(dpo[0]), 32'(tbl[v].dpo));
      chk($sformatf("tbl%0d_an", v), 0, 32'(an[0]), 32'(tbl[v].an));
    end

    // Frame ticks over 64 cycles: one per 16-cycle frame.
    lz = 1'b0;
    tc = 0;
    for (int c = 0; c < 64; c++) begin
      step();
      tc += int'(tk[0]);
    end
    chk("tick_count", 0, 32'(tc), 32'd4);

    // Load while digit 2 is mid-scan: new glyph next cycle, scan undisturbed.
    load = 1'b1; bcd = 16'h1234; dpi = 4'b0000;
    step();
    load = 1'b0;
    step_until(2, 1);
    load = 1'b1; bcd = 16'h9999;
    step();
    load = 1'b0;
    step();
    chk("midload_seg", 0, 32'(seg[0]), 32'b1111011);
    chk("midload_an",  0, 32'(an[0]),  32'b0100);

    // Active-low pins with an 8 on digit 0.
    load = 1'b1; bcd = 16'h0008;
    step();
    load = 1'b0;
    step_until(0, -1);
    chk("lo8_seg", 2, 32'(seg[2]), 32'b0000000);
    chk("lo8_an",  2, 32'(an[2]),  32'b1110);

    // Reset mid-digit restarts the scan at digit 0 with cleared data.
    load = 1'b1; bcd = 16'h5678;
    step();
    load = 1'b0;
    step_until(2, 2);
    rst_pulse();
    step();
    chk("rstmid_seg", 0, 32'(seg[0]), 32'b1111110);
    chk("rstmid_an",  0, 32'(an[0]),  32'b0001);

    // Randomised traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      load = ($urandom_range(0, 7) == 0);
      for (int d = 0; d < 4; d++)
        bcd[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      dpi = 4'($urandom);
      if (c % 37 == 0) lz = 1'($urandom);
      if ($urandom_range(0, 299) == 0) rst_pulse();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
